// File: rtl/idu_pipe.sv
// rtl/idu_pipe.sv - Registered RV32I/RV64I(+M, Zicsr, fence, system) decode stage
// with valid/ready handshake, 2-entry skid buffer and flush.
module idu_pipe #(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_inst_i,
  input  logic [PC_W-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PC_W-1:0] out_pc_o,
  output logic [4:0]      out_rs1_o,
  output logic [4:0]      out_rs2_o,
  output logic [4:0]      out_rd_o,
  output logic            out_rd_we_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [5:0]      out_cls_o,
  output logic [2:0]      out_funct3_o,
  output logic            out_alt_o,
  output logic            out_word_o,
  output logic            out_op2imm_o,
  output logic            out_illegal_o
);

  localparam bit IS_64 = (XLEN == 64);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Class bit order: {sys, mem, csr, muldiv, bjp, alu}
  localparam logic [5:0] CLS_ALU = 6'b000001;
  localparam logic [5:0] CLS_BJP = 6'b000010;
  localparam logic [5:0] CLS_MD  = 6'b000100;
  localparam logic [5:0] CLS_CSR = 6'b001000;
  localparam logic [5:0] CLS_MEM = 6'b010000;
  localparam logic [5:0] CLS_SYS = 6'b100000;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic [5:0]      cls;
    logic [2:0]      funct3;
    logic            alt;
    logic            word;
    logic            op2imm;
    logic            illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = in_inst_i[6:0];
  assign f3     = in_inst_i[14:12];
  assign f7     = in_inst_i[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, imm_sh5, imm_sh6;
  assign imm_i   = XLEN'($signed(in_inst_i[31:20]));
  assign imm_s   = XLEN'($signed({in_inst_i[31:25], in_inst_i[11:7]}));
  assign imm_b   = XLEN'($signed({in_inst_i[31], in_inst_i[7], in_inst_i[30:25],
                                  in_inst_i[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({in_inst_i[31:12], 12'b0}));
  assign imm_j   = XLEN'($signed({in_inst_i[31], in_inst_i[19:12], in_inst_i[20],
                                  in_inst_i[30:21], 1'b0}));
  assign imm_z   = XLEN'(in_inst_i[19:15]);
  assign imm_sh5 = XLEN'(in_inst_i[24:20]);
  assign imm_sh6 = XLEN'(in_inst_i[25:20]);

  logic            legal, rs1_rd, rs2_rd, rd_wr, alt, word, op2imm;
  logic [5:0]      cls;
  logic [XLEN-1:0] imm;

  always_comb begin
    legal  = 1'b0;
    rs1_rd = 1'b0;
    rs2_rd = 1'b0;
    rd_wr  = 1'b0;
    alt    = 1'b0;
    word   = 1'b0;
    op2imm = 1'b0;
    cls    = 6'b0;
    imm    = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        legal = 1'b1; cls = CLS_ALU; rd_wr = 1'b1; op2imm = 1'b1; imm = imm_u;
      end
      OP_JAL: begin
        legal = 1'b1; cls = CLS_BJP; rd_wr = 1'b1; imm = imm_j;
      end
      OP_JALR: begin
        legal = (f3 == 3'b000); cls = CLS_BJP; rs1_rd = 1'b1; rd_wr = 1'b1; imm = imm_i;
      end
      OP_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        cls = CLS_BJP; rs1_rd = 1'b1; rs2_rd = 1'b1; imm = imm_b;
      end
      OP_LOAD: begin
        legal = (f3 != 3'b111) && (IS_64 || (f3 != 3'b011 && f3 != 3'b110));
        cls = CLS_MEM; rs1_rd = 1'b1; rd_wr = 1'b1; op2imm = 1'b1; imm = imm_i;
      end
      OP_STORE: begin
        legal = (f3 <= 3'b010) || (IS_64 && f3 == 3'b011);
        cls = CLS_MEM; rs1_rd = 1'b1; rs2_rd = 1'b1; op2imm = 1'b1; imm = imm_s;
      end
      OP_IMM: begin
        cls = CLS_ALU; rs1_rd = 1'b1; rd_wr = 1'b1; op2imm = 1'b1; imm = imm_i;
        legal = 1'b1;
        // Shift forms: RV64 frees inst[25] for shamt[5]; RV32 requires it clear.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm   = IS_64 ? imm_sh6 : imm_sh5;
          alt   = (f3 == 3'b101) && in_inst_i[30];
          legal = (in_inst_i[31:26] == 6'b000000 ||
                   (f3 == 3'b101 && in_inst_i[31:26] == 6'b010000)) &&
                  (IS_64 || !in_inst_i[25]);
        end
      end
      OP_IMM32: begin
        cls = CLS_ALU; rs1_rd = 1'b1; rd_wr = 1'b1; op2imm = 1'b1; word = 1'b1;
        imm = imm_i;
        legal = IS_64 && (f3 == 3'b000);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm   = imm_sh5;
          alt   = (f3 == 3'b101) && in_inst_i[30];
          legal = IS_64 && (f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000));
        end
      end
      OP_REG: begin
        rs1_rd = 1'b1; rs2_rd = 1'b1; rd_wr = 1'b1; cls = CLS_ALU;
        if (f7 == 7'b0000001) begin
          legal = 1'b1; cls = CLS_MD;
        end else if (f7 == 7'b0100000) begin
          legal = (f3 == 3'b000) || (f3 == 3'b101); alt = 1'b1;
        end else begin
          legal = (f7 == 7'b0000000);
        end
      end
      OP_REG32: begin
        rs1_rd = 1'b1; rs2_rd = 1'b1; rd_wr = 1'b1; word = 1'b1; cls = CLS_ALU;
        if (f7 == 7'b0000001) begin
          legal = IS_64 && (f3 == 3'b000 || f3 >= 3'b100); cls = CLS_MD;
        end else if (f7 == 7'b0100000) begin
          legal = IS_64 && (f3 == 3'b000 || f3 == 3'b101); alt = 1'b1;
        end else begin
          legal = IS_64 && (f7 == 7'b0000000) &&
                  (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
        end
      end
      OP_MISC: begin
        legal = (f3 == 3'b000) || (f3 == 3'b001); cls = CLS_SYS;
      end
      OP_SYSTEM: begin
        if (f3 == 3'b000) begin
          cls   = CLS_SYS;
          legal = (in_inst_i == 32'h0000_0073) || (in_inst_i == 32'h0010_0073) ||
                  (in_inst_i == 32'h3020_0073);
        end else if (f3 != 3'b100) begin
          legal  = 1'b1; cls = CLS_CSR; rd_wr = 1'b1;
          rs1_rd = !f3[2];
          imm    = f3[2] ? imm_z : '0;
        end
      end
      default: ;
    endcase
  end

  entry_t dec;
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc_i;
    dec.funct3  = f3;
    dec.illegal = !legal;
    if (legal) begin
      dec.rs1    = rs1_rd ? in_inst_i[19:15] : 5'd0;
      dec.rs2    = rs2_rd ? in_inst_i[24:20] : 5'd0;
      dec.rd     = rd_wr ? in_inst_i[11:7] : 5'd0;
      dec.rd_we  = rd_wr;
      dec.imm    = imm;
      dec.cls    = cls;
      dec.alt    = alt;
      dec.word   = word;
      dec.op2imm = op2imm;
    end
  end

  entry_t m_q, m_d, s_q, s_d;
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic   accept, fire;

  assign in_ready_o  = !s_valid_q;
  assign out_valid_o = m_valid_q;
  assign accept      = in_valid_i && in_ready_o;
  assign fire        = m_valid_q && out_ready_i;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      if (fire) begin
        m_d       = s_q;
        s_valid_d = 1'b0;
      end
    end else if (m_valid_q) begin
      if (accept && fire) begin
        m_d = dec;
      end else if (accept) begin
        s_d       = dec;
        s_valid_d = 1'b1;
      end else if (fire) begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      m_d       = dec;
      m_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign out_pc_o      = m_q.pc;
  assign out_rs1_o     = m_q.rs1;
  assign out_rs2_o     = m_q.rs2;
  assign out_rd_o      = m_q.rd;
  assign out_rd_we_o   = m_q.rd_we;
  assign out_imm_o     = m_q.imm;
  assign out_cls_o     = m_q.cls;
  assign out_funct3_o  = m_q.funct3;
  assign out_alt_o     = m_q.alt;
  assign out_word_o    = m_q.word;
  assign out_op2imm_o  = m_q.op2imm;
  assign out_illegal_o = m_q.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// tb/tb_idu_pipe.sv - Directed self-checking bench for idu_pipe, run against
// an RV64 and an RV32 instance sharing the same input stimulus.
module tb_idu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_inst_i = '0;
  logic [63:0] in_pc_i = '0;
  logic        out_ready_i = 1'b0;

  logic        a_in_ready, a_valid, a_rd_we, a_alt, a_word, a_op2imm, a_illegal;
  logic [63:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [5:0]  a_cls;
  logic [2:0]  a_f3;

  logic        b_in_ready, b_valid, b_rd_we, b_alt, b_word, b_op2imm, b_illegal;
  logic [63:0] b_pc;
  logic [31:0] b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [5:0]  b_cls;
  logic [2:0]  b_f3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  idu_pipe #(.XLEN(64), .PC_W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(a_in_ready), .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
    .out_valid_o(a_valid), .out_ready_i(out_ready_i), .out_pc_o(a_pc),
    .out_rs1_o(a_rs1), .out_rs2_o(a_rs2), .out_rd_o(a_rd), .out_rd_we_o(a_rd_we),
    .out_imm_o(a_imm), .out_cls_o(a_cls), .out_funct3_o(a_f3), .out_alt_o(a_alt),
    .out_word_o(a_word), .out_op2imm_o(a_op2imm), .out_illegal_o(a_illegal)
  );

  idu_pipe #(.XLEN(32), .PC_W(64)) u32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(b_in_ready), .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
    .out_valid_o(b_valid), .out_ready_i(out_ready_i), .out_pc_o(b_pc),
    .out_rs1_o(b_rs1), .out_rs2_o(b_rs2), .out_rd_o(b_rd), .out_rd_we_o(b_rd_we),
    .out_imm_o(b_imm), .out_cls_o(b_cls), .out_funct3_o(b_f3), .out_alt_o(b_alt),
    .out_word_o(b_word), .out_op2imm_o(b_op2imm), .out_illegal_o(b_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [63:0] pc);
    in_valid_i = 1'b1;
    in_inst_i  = inst;
    in_pc_i    = pc;
  endtask

  task automatic test_reset();
    #3;
    tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", a_valid); end
    tests_run++; if ({a_pc, a_imm, a_rd, a_cls} !== '0) begin tests_failed++; $display("FAIL reset_payload: got pc=%h imm=%h rd=%0d cls=%b exp all 0", a_pc, a_imm, a_rd, a_cls); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b exp 1", a_in_ready); end
  endtask

  task automatic test_addi();
    out_ready_i = 1'b1;
    push(32'h0050_0093, 64'h1000);
    step();
    in_valid_i = 1'b0;
    tests_run++; if (a_valid !== 1'b1) begin tests_failed++; $display("FAIL addi_valid: got %b exp 1", a_valid); end
    tests_run++; if ({a_rd, a_rd_we, a_rs1, a_rs2} !== {5'd1, 1'b1, 5'd0, 5'd0}) begin tests_failed++; $display("FAIL addi_regs: got rd=%0d we=%b rs1=%0d rs2=%0d exp 1 1 0 0", a_rd, a_rd_we, a_rs1, a_rs2); end
    tests_run++; if (a_imm !== 64'd5) begin tests_failed++; $display("FAIL addi_imm: got %h exp 5", a_imm); end
    tests_run++; if ({a_cls, a_op2imm, a_illegal} !== {6'b000001, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL addi_cls: got cls=%b op2imm=%b ill=%b exp 000001 1 0", a_cls, a_op2imm, a_illegal); end
    tests_run++; if (a_pc !== 64'h1000) begin tests_failed++; $display("FAIL addi_pc: got %h exp 1000", a_pc); end
    step();
    tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL addi_drain: got %b exp 0", a_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b0;
    push(32'h0050_0093, 64'h100);
    step();
    push(32'h00A0_0113, 64'h104);
    step();
    tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_ready: got %b exp 0", a_in_ready); end
    push(32'h0030_0193, 64'h108);
    step();
    tests_run++; if ({a_valid, a_rd, a_pc} !== {1'b1, 5'd1, 64'h100}) begin tests_failed++; $display("FAIL bp_hold: got v=%b rd=%0d pc=%h exp 1 1 100", a_valid, a_rd, a_pc); end
    out_ready_i = 1'b1;
    step();
    tests_run++; if ({a_rd, a_pc} !== {5'd2, 64'h104}) begin tests_failed++; $display("FAIL bp_second: got rd=%0d pc=%h exp 2 104", a_rd, a_pc); end
    tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_after_fire: got %b exp 1", a_in_ready); end
    step();
    in_valid_i = 1'b0;
    tests_run++; if ({a_valid, a_rd, a_pc} !== {1'b1, 5'd3, 64'h108}) begin tests_failed++; $display("FAIL bp_third: got v=%b rd=%0d pc=%h exp 1 3 108", a_valid, a_rd, a_pc); end
    step();
    tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty: got %b exp 0", a_valid); end
  endtask

  task automatic test_xlen();
    out_ready_i = 1'b1;
    push(32'h0211_1113, 64'h200);
    step();
    tests_run++; if ({a_imm, a_illegal, a_rd, a_rs1} !== {64'd33, 1'b0, 5'd2, 5'd2}) begin tests_failed++; $display("FAIL slli64: got imm=%0d ill=%b rd=%0d rs1=%0d exp 33 0 2 2", a_imm, a_illegal, a_rd, a_rs1); end
    tests_run++; if ({b_illegal, b_cls, b_rd_we, b_rd, b_imm} !== {1'b1, 6'b0, 1'b0, 5'd0, 32'd0}) begin tests_failed++; $display("FAIL slli32: got ill=%b cls=%b we=%b rd=%0d imm=%h exp 1 0 0 0 0", b_illegal, b_cls, b_rd_we, b_rd, b_imm); end
    push(32'h0080_B283, 64'h204);
    step();
    tests_run++; if ({a_cls, a_imm, a_rd, a_rs1, a_f3, a_illegal} !== {6'b010000, 64'd8, 5'd5, 5'd1, 3'b011, 1'b0}) begin tests_failed++; $display("FAIL ld64: got cls=%b imm=%0d rd=%0d rs1=%0d f3=%b ill=%b exp 010000 8 5 1 011 0", a_cls, a_imm, a_rd, a_rs1, a_f3, a_illegal); end
    tests_run++; if ({b_illegal, b_cls} !== {1'b1, 6'b0}) begin tests_failed++; $display("FAIL ld32: got ill=%b cls=%b exp 1 0", b_illegal, b_cls); end
    push(32'hFFF0_809B, 64'h208);
    step();
    tests_run++; if ({a_word, a_imm, a_illegal} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}) begin tests_failed++; $display("FAIL addiw64: got w=%b imm=%h ill=%b exp 1 ffffffffffffffff 0", a_word, a_imm, a_illegal); end
    tests_run++; if (b_illegal !== 1'b1) begin tests_failed++; $display("FAIL addiw32: got ill=%b exp 1", b_illegal); end
    in_valid_i = 1'b0;
    step();
  endtask

  task automatic test_decode_table();
    logic [31:0] t_inst [7] = '{32'h4020_81B3, 32'h0220_81B3, 32'h0000_0073, 32'h0020_8463,
                                32'hFFFF_FFFF, 32'h8000_00B7, 32'h3002_D0F3};
    logic [5:0]  t_cls  [7] = '{6'b000001, 6'b000100, 6'b100000, 6'b000010,
                                6'b000000, 6'b000001, 6'b001000};
    logic [63:0] t_imm  [7] = '{64'd0, 64'd0, 64'd0, 64'd8,
                                64'd0, 64'hFFFF_FFFF_8000_0000, 64'd5};
    logic [16:0] t_regs [7] = '{{5'd1, 5'd2, 5'd3, 1'b1, 1'b1}, {5'd1, 5'd2, 5'd3, 1'b1, 1'b0},
                                {5'd0, 5'd0, 5'd0, 1'b0, 1'b0}, {5'd1, 5'd2, 5'd0, 1'b0, 1'b0},
                                {5'd0, 5'd0, 5'd0, 1'b0, 1'b0}, {5'd0, 5'd0, 5'd1, 1'b1, 1'b0},
                                {5'd0, 5'd0, 5'd1, 1'b1, 1'b0}};
    logic        t_ill  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push(t_inst[i], 64'h300 + 64'(i * 4));
      step();
      tests_run++; if ({a_cls, a_illegal} !== {t_cls[i], t_ill[i]}) begin tests_failed++; $display("FAIL tbl%0d_cls: got cls=%b ill=%b exp %b %b", i, a_cls, a_illegal, t_cls[i], t_ill[i]); end
      tests_run++; if (a_imm !== t_imm[i]) begin tests_failed++; $display("FAIL tbl%0d_imm: got %h exp %h", i, a_imm, t_imm[i]); end
      tests_run++; if ({a_rs1, a_rs2, a_rd, a_rd_we, a_alt} !== t_regs[i]) begin tests_failed++; $display("FAIL tbl%0d_regs: got %h exp %h", i, {a_rs1, a_rs2, a_rd, a_rd_we, a_alt}, t_regs[i]); end
    end
    in_valid_i = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    push(32'h0050_0093, 64'h400);
    step();
    push(32'h00A0_0113, 64'h404);
    step();
    push(32'h0030_0193, 64'h408);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    tests_run++; if ({a_valid, a_in_ready} !== 2'b01) begin tests_failed++; $display("FAIL flush_state: got v=%b rdy=%b exp 0 1", a_valid, a_in_ready); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_ghost%0d: got %b exp 0", i, a_valid); end
    end
    push(32'h0040_0213, 64'h40C);
    step();
    in_valid_i = 1'b0;
    tests_run++; if ({a_valid, a_rd, a_pc} !== {1'b1, 5'd4, 64'h40C}) begin tests_failed++; $display("FAIL flush_resume: got v=%b rd=%0d pc=%h exp 1 4 40c", a_valid, a_rd, a_pc); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready_i = 1'b0;
    push(32'h0050_0093, 64'h500);
    step();
    in_valid_i = 1'b0;
    tests_run++; if (a_valid !== 1'b1) begin tests_failed++; $display("FAIL arst_pre: got %b exp 1", a_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_valid: got %b exp 0", a_valid); end
    tests_run++; if ({a_pc, a_imm, a_rd, a_rd_we, a_cls} !== '0) begin tests_failed++; $display("FAIL arst_payload: got pc=%h imm=%h rd=%0d exp 0", a_pc, a_imm, a_rd); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    out_ready_i = 1'b1;
    push(32'h00A0_0113, 64'h504);
    step();
    in_valid_i = 1'b0;
    tests_run++; if ({a_valid, a_rd, a_pc} !== {1'b1, 5'd2, 64'h504}) begin tests_failed++; $display("FAIL arst_resume: got v=%b rd=%0d pc=%h exp 1 2 504", a_valid, a_rd, a_pc); end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_xlen();
    test_decode_table();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/idu_pipe.md
Name: idu_pipe

Overview:
- Registered RISC-V decode stage between the IF and EX stages.
- Decodes RV32I/RV64I plus M, Zicsr, fence/fence.i, ecall/ebreak/mret. Base is selected by parameter XLEN.
- Adds illegal-instruction detection, a valid/ready handshake on both sides, a 2-entry skid buffer for full-throughput backpressure, and a pipeline flush.
- Outputs are register addresses, immediate, a one-hot class, and function qualifiers for EX.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. 64 enables OP-32/OP-IMM-32 (W ops), ld, lwu, sd, and 6-bit shamt.
- PC_W, 64, PC width carried alongside the instruction.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous kill of all buffered entries
- in_valid_i  in  1  IF holds a valid instruction
- in_ready_o  out  1  decode can accept
- in_inst_i  in  32  instruction word
- in_pc_i  in  PC_W  instruction PC
- out_valid_o  out  1  decoded entry available
- out_ready_i  in  1  EX accepts
- out_pc_o  out  PC_W  PC of entry
- out_rs1_o  out  5  rs1 address; 0 when rs1 is not read
- out_rs2_o  out  5  rs2 address; 0 when rs2 is not read
- out_rd_o  out  5  rd address; 0 when rd is not written
- out_rd_we_o  out  1  rd write enable
- out_imm_o  out  XLEN  selected immediate, sign/zero-extended to XLEN
- out_cls_o  out  6  one-hot {sys,mem,csr,muldiv,bjp,alu}; 0 when illegal
- out_funct3_o  out  3  funct3 passthrough
- out_alt_o  out  1  inst[30] for sub/sra/srai; 0 otherwise
- out_word_o  out  1  W-form op (XLEN=64 only)
- out_op2imm_o  out  1  ALU operand 2 is the immediate
- out_illegal_o  out  1  unrecognised or disallowed encoding

Behaviour:
- Reset (rst_n=0, asynchronous): both buffer entries invalid; out_valid_o=0; all payload outputs 0; in_ready_o=1 on the first cycle after release.
- Decode logic is combinational on in_inst_i. The result is captured with the PC on acceptance (in_valid_i & in_ready_o).
- Latency: accepted at edge N, visible on outputs from N+1.
- Buffer: main register M drives the outputs; skid register S sits behind it.
  - in_ready_o = ~S.valid (registered, no combinational path from out_ready_i).
- States by valid count:
  - EMPTY: accept → ONE.
  - ONE:
    - accept & out fire → stays ONE; M loads the new entry.
    - accept & no fire → FULL; S loads.
    - fire only → EMPTY.
  - FULL: in_ready_o=0. Fire → ONE; M ← S.
- Order is strictly FIFO. An entry never changes while out_valid_o=1 & out_ready_i=0.
- flush_i=1: on the next edge both entries become invalid. An input presented the same cycle is dropped. Flush has priority over accept and fire.
- Illegal detection:
  - out_illegal_o=1 for any opcode/funct3/funct7 combination outside the supported set.
  - With XLEN=32, these are illegal: opcodes 0011011/0111011, ld/lwu/sd, and shamt bit 5 = 1.
  - On illegal: out_cls_o=0, out_rd_we_o=0, and rs1/rs2/rd/imm = 0.
  - Illegal entries still flow through the handshake.
- Immediates:
  - U: sign-extended from inst[31].
  - I, S, B, J: sign-extended to XLEN.
  - CSR-immediate forms: zimm inst[19:15] zero-extended.
  - Shifts: shamt zero-extended; 5 bits for W forms or XLEN=32, else 6 bits.
  - All other instructions: imm=0.
- Register-access rules:
  - rs1 is read by all except lui, auipc, jal, csr*i, ecall, ebreak, mret, fence, fence.i.
  - rs2 is read only by OP, OP-32, store, branch.
  - rd is written by lui, auipc, jal, jalr, load, OP-IMM(-32), OP(-32), and csr*.
- out_op2imm_o = 1 for OP-IMM(-32), lui, auipc, load, store.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 → one cycle later: rd=1, rd_we=1, rs1=0, rs2=0, imm=5, cls=000001, op2imm=1, illegal=0.
- out_ready=0; push 0x00500093 then 0x00A00113 → after 2 cycles in_ready=0 with S full. Raise out_ready → entries emerge in order (rd=1, then rd=2), in_ready=1 one cycle after the first fire, no loss or duplication.
- XLEN=64, slli x2,x2,33 (0x02111113) → imm=33, illegal=0. XLEN=32, same word → illegal=1, cls=0, rd_we=0.
- XLEN=32, ld x5,8(x1) (0x0080B283) → illegal=1. XLEN=64 → cls=mem, imm=8, rd=5, funct3=011.
- FULL state with a third valid input, flush_i=1 → next cycle out_valid=0, in_ready=1, and no flushed or dropped entry ever appears.
- Assert rst_n=0 mid-stream with out_valid=1 → out_valid drops immediately (asynchronous), payloads=0. Streaming resumes cleanly after release.
